cpld_bus_master: RTL and testbench
==================================

// Module: cpld_bus_master
// PURPOSE
// - Initiator side of the CPLD/ARM async strobe bus that the FPGA BIU decodes.
// - Turns a valid/ready request (read or write, word address, write data) into timed
//   cpld_rs/cpld_ws strobes with address/data setup, hold and recovery.
// - Returns read data or write completion on a one-cycle response.
// - Used as the host-side bus engine and as the stimulus driver for BIU benches.
// PARAMETERS
// ADDR_W       24  width of arm_a / req_addr
// DATA_W       32  width of data bus
// SETUP_CYC     2  cycles arm_a (and write data) are stable before the strobe falls; >=1
// STROBE_CYC    6  cycles the strobe is held low; >=4 (BIU 2-flop sync + decode)
// HOLD_CYC      2  cycles arm_a and data are held after the strobe rises; >=1
// RECOVER_CYC   3  cycles strobes stay high with bus released before next accept; >=2
// PORTS
// fpga_clk      in   1       single clock
// rst           in   1       synchronous, active-high reset
// req_valid     in   1       request present
// req_ready     out  1       request accepted when valid&ready
// req_write     in   1       1=write, 0=read
// req_addr      in   ADDR_W  byte address; bits[1:0] forced to 0 on arm_a
// req_wdata     in   DATA_W  write data
// rsp_valid     out  1       one-cycle completion pulse (read and write)
// rsp_rdata     out  DATA_W  read data; 0 for writes
// busy          out  1       state != IDLE
// cpld_rs       out  1       read strobe, active-low
// cpld_ws       out  1       write strobe, active-low
// arm_a         out  ADDR_W  bus address
// arm_data_out  out  DATA_W  write data to bus tristate
// arm_data_oe   out  1       tristate enable for arm_data_out (top level owns the inout)
// arm_data_in   in   DATA_W  bus data seen at the pins
// BEHAVIOUR
// - All outputs except req_ready and busy are registered. req_ready = (state==IDLE).
// - Reset values: cpld_rs=1, cpld_ws=1, arm_a=0, arm_data_out=0, arm_data_oe=0,
//   rsp_valid=0, rsp_rdata=0, state=IDLE, count=0.
// - FSM: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE. A single down-counter
//   is loaded with N-1 on entry to each phase; the phase ends when count==0.
// - IDLE: on accept at cycle t, latch {write, addr & ~3, wdata}. Drive arm_a from t+1.
//   For writes, arm_data_oe=1 from t+1.
// - SETUP (t+1..t+S): both strobes high.
// - STROBE (next W cycles): cpld_ws=0 for writes, cpld_rs=0 for reads, exactly W cycles.
//   The other strobe stays 1. The two strobes are never low together.
// - Reads: arm_data_oe=0 for the whole transaction. arm_data_in is registered on the
//   last STROBE cycle.
// - HOLD (H cycles): strobes high; arm_a, arm_data_out and arm_data_oe unchanged.
// - RECOVER (R cycles): arm_data_oe=0; arm_a holds its value.
//   rsp_valid=1 only on the first RECOVER cycle (t+S+W+H+1; 11 with defaults).
// - Next accept is possible at t+1+S+W+H+R (14 with defaults).
//   Strobes are high for at least H+R+1+S cycles between transactions, so the BIU
//   edge detector sees every write exactly once.
// - req_valid while not IDLE: ignored (held off by req_ready=0). Request inputs are
//   sampled only on the accept cycle.
// - Reset mid-operation: on the next edge all outputs take their reset values.
//   The transaction is aborted with no rsp_valid.
// - Counter width: clog2 of the largest of S, W, H, R. No wrap: reload on every phase entry.
// STRUCTURE
// - Shared package biu_pkg:
//   - state encoding (IDLE, SETUP, STROBE, HOLD, RECOVER), ADDR_W, DATA_W;
//   - BIU map constants: LED_BASE=0x000000 with 20 words, PHOTO_BASE=0x000050 with 20 words.
// - Single module with an inline phase counter. No sub-module.
// TESTING
// - Write: addr 0x000008, data 0xDEADBEEF accepted at t.
//   -> arm_a=0x000008 from t+1; oe=1 for t+1..t+10; cpld_ws=0 exactly t+3..t+8;
//      cpld_rs=1 throughout; rsp_valid at t+11 only.
// - Read: addr 0x000050; responder drives 0x12345678 while cpld_rs=0.
//   -> oe=0 throughout; rsp_rdata=0x12345678 with rsp_valid at t+11.
// - Back-to-back: req_valid held with two writes.
//   -> second accepted at t+14; cpld_ws high for 8 cycles between the two strobes.
// - Reset asserted during the 3rd STROBE cycle.
//   -> next cycle cpld_ws=1, oe=0, req_ready=1; no rsp_valid.
// - Unaligned addr 0x000007 -> arm_a=0x000004.
// - Integration with BIU instance: write to 0x000004 -> BIU ws_vector[1] low for exactly
//   one cycle; read of 0x000000 returns the LED register value.

Source files
------------

// File: rtl/biu_pkg.sv
// Shared definitions for the CPLD/ARM async strobe bus.
// Holds the bus engine state encoding, the default bus widths, and the BIU
// register map constants. It also has a helper that sizes the phase counter.
package biu_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  // BIU register map (byte addresses, 32-bit words)
  localparam logic [23:0] LED_BASE    = 24'h000000;
  localparam int unsigned LED_WORDS   = 20;
  localparam logic [23:0] PHOTO_BASE  = 24'h000050;
  localparam int unsigned PHOTO_WORDS = 20;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRecover
  } bus_state_e;

  // Width of the down-counter. It has to hold N-1 for the longest phase, and
  // it is never narrower than one bit.
  function automatic int unsigned phase_cnt_w(input int unsigned s, input int unsigned w,
                                               input int unsigned h, input int unsigned r);
    int unsigned m;
    m = s;
    if (w > m) m = w;
    if (h > m) m = h;
    if (r > m) m = r;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cpld_bus_master.sv
// Initiator for the CPLD/ARM async strobe bus.
// A valid/ready request becomes one bus cycle with address setup, an
// active-low strobe, hold time and recovery time. Completion is signalled by
// a one-cycle rsp_valid pulse. For reads, rsp_rdata carries the data.
// Ports:
//   fpga_clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in idle)
//   req_write/addr/wdata       request contents, sampled on accept
//   rsp_valid, rsp_rdata       completion pulse and read data (0 for writes)
//   busy                       engine not idle
//   cpld_rs, cpld_ws           active-low read/write strobes
//   arm_a                      word-aligned bus address
//   arm_data_out/_oe/_in       split data bus; the top level builds the inout
module cpld_bus_master #(
  parameter int unsigned ADDR_W      = biu_pkg::ADDR_W,
  parameter int unsigned DATA_W      = biu_pkg::DATA_W,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 6,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 3
) (
  input  logic              fpga_clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              cpld_rs,
  output logic              cpld_ws,
  output logic [ADDR_W-1:0] arm_a,
  output logic [DATA_W-1:0] arm_data_out,
  output logic              arm_data_oe,
  input  logic [DATA_W-1:0] arm_data_in
);

  import biu_pkg::*;

  localparam int unsigned CntW = phase_cnt_w(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVER_CYC);

  localparam logic [CntW-1:0] SetupLoad   = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] StrobeLoad  = CntW'(STROBE_CYC - 1);
  localparam logic [CntW-1:0] HoldLoad    = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] RecoverLoad = CntW'(RECOVER_CYC - 1);

  bus_state_e        state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] arm_a_q, arm_a_d;
  logic [DATA_W-1:0] arm_data_out_q, arm_data_out_d;
  logic              arm_data_oe_q, arm_data_oe_d;
  logic              cpld_rs_q, cpld_rs_d;
  logic              cpld_ws_q, cpld_ws_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic count_zero;
  assign count_zero = (count_q == '0);

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    write_d        = write_q;
    arm_a_d        = arm_a_q;
    arm_data_out_d = arm_data_out_q;
    arm_data_oe_d  = arm_data_oe_q;
    cpld_rs_d      = cpld_rs_q;
    cpld_ws_d      = cpld_ws_q;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d        = StSetup;
          count_d        = SetupLoad;
          write_d        = req_write;
          arm_a_d        = {req_addr[ADDR_W-1:2], 2'b00};
          arm_data_out_d = req_write ? req_wdata : '0;
          arm_data_oe_d  = req_write;
        end
      end
      StSetup: begin
        if (count_zero) begin
          state_d = StStrobe;
          count_d = StrobeLoad;
          // Only one strobe ever goes low, selected by the latched direction
          if (write_q) cpld_ws_d = 1'b0;
          else         cpld_rs_d = 1'b0;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StStrobe: begin
        if (count_zero) begin
          state_d     = StHold;
          count_d     = HoldLoad;
          cpld_rs_d   = 1'b1;
          cpld_ws_d   = 1'b1;
          // Capture on the last low cycle, while the responder still drives
          rsp_rdata_d = write_q ? '0 : arm_data_in;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StHold: begin
        if (count_zero) begin
          state_d       = StRecover;
          count_d       = RecoverLoad;
          arm_data_oe_d = 1'b0;
          rsp_valid_d   = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StRecover: begin
        if (count_zero) begin
          state_d = StIdle;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state_q        <= StIdle;
      count_q        <= '0;
      write_q        <= 1'b0;
      arm_a_q        <= '0;
      arm_data_out_q <= '0;
      arm_data_oe_q  <= 1'b0;
      cpld_rs_q      <= 1'b1;
      cpld_ws_q      <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      write_q        <= write_d;
      arm_a_q        <= arm_a_d;
      arm_data_out_q <= arm_data_out_d;
      arm_data_oe_q  <= arm_data_oe_d;
      cpld_rs_q      <= cpld_rs_d;
      cpld_ws_q      <= cpld_ws_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign cpld_rs      = cpld_rs_q;
  assign cpld_ws      = cpld_ws_q;
  assign arm_a        = arm_a_q;
  assign arm_data_out = arm_data_out_q;
  assign arm_data_oe  = arm_data_oe_q;

endmodule

// File: tb/tb_cpld_bus_master.sv
// Directed bench for cpld_bus_master with the default timing (S=2, W=6, H=2, R=3).
// The accept happens at cycle t. Observations are taken 1 ns after each
// rising edge. After the k-th edge following the accept, the bench is in
// cycle t+k.
module tb_cpld_bus_master;

  logic        fpga_clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        cpld_rs;
  logic        cpld_ws;
  logic [23:0] arm_a;
  logic [31:0] arm_data_out;
  logic        arm_data_oe;
  logic [31:0] arm_data_in;
  logic [31:0] rd_word;

  int checks = 0;
  int errors = 0;
  int ws_run = 0;
  int ws_last_run = 0;

  always #5 fpga_clk = ~fpga_clk;

  // Responder: drives the read word only while the read strobe is low
  assign arm_data_in = cpld_rs ? 32'h0 : rd_word;

  // Length of the most recent run of cpld_ws high cycles
  always @(posedge fpga_clk) begin
    if (rst) begin
      ws_run <= 0;
    end else if (cpld_ws) begin
      ws_run <= ws_run + 1;
    end else begin
      if (ws_run != 0) ws_last_run <= ws_run;
      ws_run <= 0;
    end
  end

  cpld_bus_master dut (
    .fpga_clk    (fpga_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .cpld_rs     (cpld_rs),
    .cpld_ws     (cpld_ws),
    .arm_a       (arm_a),
    .arm_data_out(arm_data_out),
    .arm_data_oe (arm_data_oe),
    .arm_data_in (arm_data_in)
  );

  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction. Per-cycle checks run from t+1 to t+14, which ends in
  // the idle cycle where the next request can be accepted. With hold_valid
  // set, req_valid stays high and carries the next request.
  task automatic do_txn(input logic wr, input logic [23:0] addr, input logic [31:0] wd,
                        input logic [23:0] exp_a, input logic [31:0] exp_rd,
                        input logic hold_valid, input logic nwr,
                        input logic [23:0] naddr, input logic [31:0] nwd);
    int n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_before_accept", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    step();
    if (hold_valid) begin
      req_write = nwr;
      req_addr  = naddr;
      req_wdata = nwd;
    end else begin
      req_valid = 1'b0;
      req_write = ~wr;
      req_addr  = 24'hFFFFFF;
      req_wdata = 32'hFFFFFFFF;
    end
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("arm_a@t+%0d", c), {40'd0, arm_a}, {40'd0, exp_a});
      chk($sformatf("oe@t+%0d", c), {63'd0, arm_data_oe}, {63'd0, wr && c >= 1 && c <= 10});
      chk($sformatf("ws@t+%0d", c), {63'd0, cpld_ws}, {63'd0, !(wr && c >= 3 && c <= 8)});
      chk($sformatf("rs@t+%0d", c), {63'd0, cpld_rs}, {63'd0, !(!wr && c >= 3 && c <= 8)});
      chk($sformatf("rsp_valid@t+%0d", c), {63'd0, rsp_valid}, {63'd0, c == 11});
      chk($sformatf("ready@t+%0d", c), {63'd0, req_ready}, {63'd0, c == 14});
      if (c == 1) begin
        chk("busy@t+1", {63'd0, busy}, 64'd1);
        chk("data_out@t+1", {32'd0, arm_data_out}, {32'd0, wr ? wd : 32'h0});
      end
      if (c == 11) chk("rsp_rdata@t+11", {32'd0, rsp_rdata}, {32'd0, exp_rd});
      if (c < 14) step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rd_word   = 32'h12345678;
    step();
    step();
    step();
    chk("rst_rs", {63'd0, cpld_rs}, 64'd1);
    chk("rst_ws", {63'd0, cpld_ws}, 64'd1);
    chk("rst_arm_a", {40'd0, arm_a}, 64'd0);
    chk("rst_data_out", {32'd0, arm_data_out}, 64'd0);
    chk("rst_oe", {63'd0, arm_data_oe}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    step();

    // Write 0xDEADBEEF to 0x000008
    do_txn(1'b1, 24'h000008, 32'hDEADBEEF, 24'h000008, 32'h0, 1'b0, 1'b0, 24'h0, 32'h0);

    // Read of 0x000050 from the responder
    do_txn(1'b0, 24'h000050, 32'hCAFEF00D, 24'h000050, 32'h12345678, 1'b0, 1'b0, 24'h0,
           32'h0);

    // Unaligned read address
    rd_word = 32'h0BADF00D;
    do_txn(1'b0, 24'h000007, 32'h0, 24'h000004, 32'h0BADF00D, 1'b0, 1'b0, 24'h0, 32'h0);

    // Back-to-back writes with req_valid held. The second is accepted at t+14
    do_txn(1'b1, 24'h000004, 32'h11111111, 24'h000004, 32'h0, 1'b1, 1'b1, 24'h00000C,
           32'h22222222);
    do_txn(1'b1, 24'h00000C, 32'h22222222, 24'h00000C, 32'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    chk("ws_gap_between_writes", 64'(ws_last_run), 64'd8);

    // Reset during the 3rd strobe cycle (t+5) aborts the write
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'h000010;
    req_wdata = 32'hA5A5A5A5;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    step();
    chk("abort_ws_low@t+5", {63'd0, cpld_ws}, 64'd0);
    rst = 1'b1;
    step();
    chk("abort_ws", {63'd0, cpld_ws}, 64'd1);
    chk("abort_rs", {63'd0, cpld_rs}, 64'd1);
    chk("abort_oe", {63'd0, arm_data_oe}, 64'd0);
    chk("abort_ready", {63'd0, req_ready}, 64'd1);
    chk("abort_arm_a", {40'd0, arm_a}, 64'd0);
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("post_abort_rsp_valid@%0d", i), {63'd0, rsp_valid}, 64'd0);
      chk($sformatf("post_abort_ws@%0d", i), {63'd0, cpld_ws}, 64'd1);
    end

    // The engine still works after the abort. A write leaves rsp_rdata at 0
    do_txn(1'b1, 24'h000050, 32'h5A5A5A5A, 24'h000050, 32'h0, 1'b0, 1'b0, 24'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
